// File: rtl/sel_encoder_pkg.sv
// Shared types and helpers for the select encoder.
package sel_encoder_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CODE_W = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDead  = 2'd1,
        StGrant = 2'd2
    } state_e;

    // Binary channel index to active-high one-hot select.
    function automatic logic [NUM_CH-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
        logic [NUM_CH-1:0] oh;
        oh       = '0;
        oh[code] = 1'b1;
        return oh;
    endfunction

    // Complement for the p-side gates.
    function automatic logic [NUM_CH-1:0] sel_complement(input logic [NUM_CH-1:0] sel);
        return ~sel;
    endfunction

endpackage

// File: rtl/sel_encoder_rr_pick.sv
// Round-robin picker: first set request bit scanning from ptr upward, modulo NUM_CH.
module sel_encoder_rr_pick
    import sel_encoder_pkg::*;
(
    input  logic [NUM_CH-1:0] sreq,
    input  logic [CODE_W-1:0] ptr,
    output logic [CODE_W-1:0] win,
    output logic              any
);

    logic [CODE_W-1:0] idx;

    // Rotating priority scan; earliest hit from ptr wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = ptr + CODE_W'(i);
            if (sreq[idx] && !any) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sel_encoder.sv
// Break-before-make select encoder: synchronizes async requests, arbitrates
// round-robin, inserts one dead cycle, then holds a one-hot grant until ack.
module sel_encoder
    import sel_encoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NUM_CH-1:0] req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [NUM_CH-1:0] sel,
    output logic [NUM_CH-1:0] sel_n
);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
    logic [NUM_CH-1:0] sreq;

    state_e            state_q, state_d;
    logic [CODE_W-1:0] ptr_q, ptr_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic [NUM_CH-1:0] sel_q, sel_d;
    logic [NUM_CH-1:0] sel_n_q, sel_n_d;

    logic [CODE_W-1:0] win;
    logic              any;

    // Shift chain: stage 0 samples the raw asynchronous request lines.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req};
    end

    // Synchronizer flops, cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sreq = sync_q[SYNC_STAGES-1];

    sel_encoder_rr_pick u_rr_pick (
        .sreq (sreq),
        .ptr  (ptr_q),
        .win  (win),
        .any  (any)
    );

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        code_d  = code_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        if (!ena) begin
            // Abort keeps ptr and code so a re-enable resumes the same priority.
            state_d = StIdle;
            valid_d = 1'b0;
            sel_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid_d = 1'b0;
                    sel_d   = '0;
                    if (any) begin
                        code_d  = win;
                        state_d = StDead;
                    end
                end
                StDead: begin
                    state_d = StGrant;
                    valid_d = 1'b1;
                    sel_d   = code_to_onehot(code_q);
                end
                StGrant: begin
                    // Request drop is ignored here; only ack releases the grant.
                    if (ack) begin
                        state_d = StIdle;
                        ptr_d   = code_q + 2'd1;
                        valid_d = 1'b0;
                        sel_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    sel_d   = '0;
                end
            endcase
        end
        sel_n_d = sel_complement(sel_d);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            sel_n_q <= '1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            sel_n_q <= sel_n_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign sel   = sel_q;
    assign sel_n = sel_n_q;

endmodule

// File: tb/tb_sel_encoder.sv
// Bench for sel_encoder: directed scenarios followed by random traffic, all
// checked against a transaction-level reference model.
module tb_sel_encoder;

    localparam int S = 2;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] req;
    logic       ack;
    logic [1:0] code;
    logic       valid;
    logic [3:0] sel;
    logic [3:0] sel_n;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0=idle, 1=dead, 2=grant.
    int         m_phase;
    int         m_ptr;
    int         m_code;
    logic [3:0] m_sh [S];

    sel_encoder #(
        .SYNC_STAGES (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .req   (req),
        .ack   (ack),
        .code  (code),
        .valid (valid),
        .sel   (sel),
        .sel_n (sel_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [3:0] sreq;
        if (!rst_n) begin
            m_phase = 0;
            m_ptr   = 0;
            m_code  = 0;
            for (int k = 0; k < S; k++) m_sh[k] = 4'b0;
        end else begin
            sreq = m_sh[S-1];
            for (int k = S - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
            m_sh[0] = req;
            if (!ena) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (sreq[(m_ptr + k) % 4]) begin
                        m_code  = (m_ptr + k) % 4;
                        m_phase = 1;
                        break;
                    end
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (ack) begin
                m_ptr   = (m_code + 1) % 4;
                m_phase = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] esel;
        esel = (m_phase == 2) ? (4'b0001 << m_code) : 4'b0000;
        chk("m_valid", {3'b0, valid}, {3'b0, m_phase == 2});
        chk("m_code", {2'b0, code}, 4'(m_code));
        chk("m_sel", sel, esel);
        chk("m_sel_n", sel_n, ~esel);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        checks++;
        assert (valid === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed valid=%b after %0d cycles expected 1", tag, valid, n);
        end
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n = 1'b0;
        ena   = 1'b1;
        req   = 4'b0;
        ack   = 1'b0;

        // Reset held two cycles.
        step();
        step();
        chk("rst_code", {2'b0, code}, 4'b0000);
        chk("rst_valid", {3'b0, valid}, 4'b0000);
        chk("rst_sel", sel, 4'b0000);
        chk("rst_sel_n", sel_n, 4'b1111);

        // Single request, ptr=0: dead after edge 2, grant after edge 3.
        rst_n = 1'b1;
        req   = 4'b0100;
        step();
        step();
        step();
        chk("single_dead_valid", {3'b0, valid}, 4'b0000);
        chk("single_dead_sel", sel, 4'b0000);
        step();
        chk("single_valid", {3'b0, valid}, 4'b0001);
        chk("single_code", {2'b0, code}, 4'b0010);
        chk("single_sel", sel, 4'b0100);
        chk("single_sel_n", sel_n, 4'b1011);
        req = 4'b0000;
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("single_ack_valid", {3'b0, valid}, 4'b0000);

        // Round robin from ptr=0 with all requests held.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_valid("rr_wait", 10);
            chk("rr_code", {2'b0, code}, {2'b0, rr_exp[g]});
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk("rr_gap_sel", sel, 4'b0000);
            step();
            chk("rr_dead_sel", sel, 4'b0000);
        end

        // Wrap: make ptr=3, then req=0011 must pick channel 0 before channel 1.
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
        req   = 4'b0100;
        wait_valid("wrap_setup", 10);
        chk("wrap_setup_code", {2'b0, code}, 4'b0010);
        req = 4'b0000;
        repeat (3) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        req = 4'b0011;
        wait_valid("wrap_wait0", 10);
        chk("wrap_code0", {2'b0, code}, 4'b0000);
        ack = 1'b1;
        step();
        ack = 1'b0;
        wait_valid("wrap_wait1", 10);
        chk("wrap_code1", {2'b0, code}, 4'b0001);

        // Hold: requests vanish while granted, no ack.
        req = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold_valid", {3'b0, valid}, 4'b0001);
            chk("hold_code", {2'b0, code}, 4'b0001);
            chk("hold_sel", sel, 4'b0010);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;

        // Abort via ena, then resume, then reset mid-grant.
        req = 4'b0100;
        wait_valid("abort_wait", 10);
        chk("abort_code", {2'b0, code}, 4'b0010);
        ena = 1'b0;
        step();
        chk("abort_valid", {3'b0, valid}, 4'b0000);
        chk("abort_sel", sel, 4'b0000);
        chk("abort_sel_n", sel_n, 4'b1111);
        ena = 1'b1;
        wait_valid("resume_wait", 10);
        chk("resume_code", {2'b0, code}, 4'b0010);
        chk("resume_sel", sel, 4'b0100);
        rst_n = 1'b0;
        step();
        chk("midrst_code", {2'b0, code}, 4'b0000);
        chk("midrst_valid", {3'b0, valid}, 4'b0000);
        chk("midrst_sel", sel, 4'b0000);
        chk("midrst_sel_n", sel_n, 4'b1111);
        rst_n = 1'b1;
        req   = 4'b0000;

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            req   = 4'($urandom);
            ack   = ($urandom_range(0, 2) == 0);
            ena   = ($urandom_range(0, 15) != 0);
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sel_encoder.md
SEL_ENCODER -- requirements
Module: sel_encoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on each req bit; legal range 2..3.
REQ-002 clk  input  1  single clock for all state.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 ena  input  1  block enable; low forces return to IDLE.
REQ-005 req  input  4  asynchronous request lines, one per mux channel n0..n3/p0..p3.
REQ-006 ack  input  1  consumer accepts current grant; sampled only in GRANT.
REQ-007 code  output  2  binary index of granted channel, same encoding as the control_decoder input of the decoder.
REQ-008 valid  output  1  high only in GRANT.
REQ-009 sel  output  4  one-hot select, active-high, for n-side gates.
REQ-010 sel_n  output  4  bitwise complement of sel, for p-side gates.

Function
REQ-011 Each req bit SHALL pass through SYNC_STAGES flops before use; only synchronized req (sreq) drives decisions.
REQ-012 FSM states: IDLE, DEAD, GRANT; all outputs registered.
REQ-013 IDLE: sel=0000, valid=0; if sreq!=0, capture winner into code, go DEAD; else stay.
REQ-014 Winner = first set bit of sreq scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-015 DEAD: sel=0000, valid=0, exactly one cycle (break-before-make); go GRANT unconditionally.
REQ-016 GRANT: valid=1, sel=one-hot(code), code stable; stay until ack=1 sampled.
REQ-017 GRANT with ack=1: next cycle IDLE, ptr <= code+1 with 2-bit wrap (3 -> 0).
REQ-018 Request deassertion in DEAD or GRANT SHALL NOT drop the grant; only ack or ena=0 ends it.
REQ-019 ack in IDLE or DEAD SHALL be ignored.
REQ-020 ena=0 in any state: next cycle IDLE, sel=0000, valid=0; ptr and code unchanged.
REQ-021 sel_n SHALL equal ~sel at every clock edge, including reset.
REQ-022 Latency: req stable high before edge 0 -> valid=1 after edge SYNC_STAGES+1 (edge 3 at default).
REQ-023 Minimum grant period IDLE->DEAD->GRANT->IDLE = 3 cycles; back-to-back requests SHALL each pass through DEAD.

Reset
REQ-024 rst_n=0 at edge: state=IDLE, ptr=0, code=00, valid=0, sel=0000, sel_n=1111, sync flops=0.
REQ-025 Reset mid-GRANT SHALL take effect at that edge with no DEAD cycle and no ptr update.

Structure
REQ-026 Shared package holds NUM_CH=4, CODE_W=2, state enum, and one-hot/complement helper.
REQ-027 One sub-module rr_pick (combinational: sreq, ptr -> winner code, any) SHALL be instantiated once.

Verification
REQ-028 Reset: rst_n=0 two cycles -> code=00, valid=0, sel=0000, sel_n=1111.
REQ-029 Single request: req=0100 held, ptr=0 -> DEAD after edge 2, GRANT after edge 3, code=10, sel=0100, sel_n=1011; ack one cycle -> IDLE, ptr=3.
REQ-030 Round-robin: req=1111 held, ack every GRANT -> codes 0,1,2,3,0 in order, sel=0000 in each IDLE/DEAD between grants.
REQ-031 Wrap/priority: ptr=3, req=0011 -> code=00 (not 01); after ack ptr=1, next code=01.
REQ-032 Hold: GRANT code=01, req drops to 0000 for 5 cycles, ack=0 -> valid, code, sel unchanged.
REQ-033 Abort: ena=0 in GRANT code=10 -> next cycle IDLE, sel=0000; ena=1 with req=0100 -> code=10 again (ptr unchanged); rst_n=0 in GRANT -> reset values at that edge.
